sd_sampler_n: RTL and testbench
===============================

Name: sd_sampler_n

Overview:
- Parametrised N-channel discrete-signal sampler. Successor to the fixed four-channel DCxS sampler latches.
- Each channel samples a raw discrete on a timing strobe when its gate condition is true, filters it over consecutive agreeing samples, and holds the confirmed state.
- Per-channel level or sticky mode.
- Latched word can be shifted out serially to the data-input path under a request/busy handshake.

Parameters:
- NCH, 4, number of discrete channels (1..32).
- FILT, 3, consecutive agreeing gated samples required to update a channel (1..7).

Ports:
- SIM_CLK  input  1  system clock; all state updates on rising edge.
- SIM_RST  input  1  reset, asynchronous, active-high.
- SAMP  input  1  sample strobe; one-cycle pulse per sample time.
- DIN  input  NCH  raw discrete inputs.
- GATE  input  NCH  per-channel sample enable (pre-decoded gate condition).
- STICKY  input  NCH  per-channel mode: 0 = level, 1 = sticky-set.
- CLR  input  1  synchronous clear of all channel state.
- RD_REQ  input  1  start serial readout; one-cycle pulse.
- DCS  output  NCH  confirmed (latched) channel states.
- DCSN  output  NCH  bitwise complement of DCS, registered alongside it.
- SD_OUT  output  1  serial readout data.
- SD_VALID  output  1  high on each cycle SD_OUT carries a bit.
- RD_BUSY  output  1  readout in progress.

Behaviour:
- Reset (async, SIM_RST=1):
  - DCS=0, DCSN=all ones, SD_OUT=0, SD_VALID=0, RD_BUSY=0.
  - Per-channel candidate=0, count=0; FSM=IDLE.
  - Deassertion is honoured on the next clock edge.
- Per-channel state: candidate bit cand[i] and counter cnt[i], width 3, saturating at FILT.
- Gated sample (SAMP=1 and GATE[i]=1), channel i:
  - If DIN[i]==cand[i]: cnt[i] <= min(cnt[i]+1, FILT).
  - Else: cand[i] <= DIN[i], cnt[i] <= 1.
  - Confirmation occurs in the same cycle when the updated count equals FILT.
  - Level mode: on confirmation, DCS[i] <= new cand.
  - Sticky mode: on confirmation of 1, DCS[i] <= 1. Confirmation of 0 does not change DCS[i]; only CLR or reset clears it.
  - DCS/DCSN change on the clock edge that registers the confirming sample (1-cycle latency from the strobe).
  - FILT=1: every gated sample confirms immediately.
- Ungated channel or SAMP=0: cand, cnt and DCS hold (the hold-latch function). DIN is ignored.
- CLR=1: DCS=0, DCSN=all ones, all cand=0, cnt=0 next edge. CLR has priority over a same-cycle SAMP.
- STICKY change takes effect at the next confirmation; it never alters DCS by itself.
- Readout FSM, states IDLE and SHIFT, bit index k of width clog2(NCH), minimum 1:
  - IDLE, RD_REQ=1: snapshot <= DCS as registered before that edge's sample/CLR updates; k <= 0; go to SHIFT.
  - SHIFT: SD_OUT = snapshot[k], SD_VALID=1, RD_BUSY=1. k increments each cycle. After bit NCH-1 is presented, return to IDLE next edge.
  - Bits go out LSB (channel 0) first over exactly NCH consecutive cycles. First bit appears the cycle after RD_REQ.
  - IDLE: SD_VALID=0, SD_OUT=0, RD_BUSY=0.
  - RD_REQ while in SHIFT is ignored (not queued).
  - RD_REQ on the cycle SHIFT returns to IDLE is also ignored.
  - CLR or sampling during SHIFT does not affect the shifting snapshot.
  - Reset mid-readout aborts immediately to IDLE with outputs at reset values.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then idle: DCS=0000, DCSN=1111, RD_BUSY=0. Assert SIM_RST asynchronously between edges mid-readout -> outputs return to reset values without waiting for a clock.
- FILT=3, ch0 level, GATE[0]=1, DIN[0]=1, three SAMP pulses -> DCS[0] stays 0 after pulses 1 and 2, becomes 1 one cycle after pulse 3. Pattern 1,1,0,1,1 -> no update until the 3rd consecutive 1 following the 0.
- GATE[1]=0 with DIN[1] toggling over 10 strobes -> DCS[1], cand and cnt unchanged. Raise GATE[1] -> filtering restarts from the held candidate.
- ch2 sticky, FILT=1: DIN[2]=1 strobe -> DCS[2]=1. DIN[2]=0 strobes -> DCS[2] stays 1. CLR together with SAMP -> DCS[2]=0 and cnt=0.
- DCS=1010 (NCH=4), RD_REQ pulse -> SD_VALID high for 4 cycles starting the next cycle, SD_OUT=0,1,0,1. RD_BUSY high for those 4 cycles. A second RD_REQ on cycle 2 is ignored.
- RD_REQ in the same cycle a confirming sample sets DCS[3] -> shifted bit 3 carries the old value, and DCS[3]=1 afterwards.

Source files
------------

// File: rtl/sd_sampler_n.sv
// ----------------------------------------------------------------------------
// sd_sampler_n
//   N-channel discrete-signal sampler. Each channel takes a gated sample of
//   its raw discrete on the sample strobe, requires FILT consecutive agreeing
//   samples before updating its confirmed state, and holds that state between
//   gated samples. Channels run in level mode or sticky-set mode. The confirmed
//   word can be snapshotted and shifted out serially, channel 0 first.
//
// Ports
//   SIM_CLK   in   system clock, rising edge
//   SIM_RST   in   asynchronous active-high reset
//   SAMP      in   sample strobe (one-cycle pulse)
//   DIN       in   [NCH] raw discrete inputs
//   GATE      in   [NCH] per-channel sample enable
//   STICKY    in   [NCH] per-channel mode, 0 = level, 1 = sticky-set
//   CLR       in   synchronous clear of all channel state
//   RD_REQ    in   start serial readout (one-cycle pulse)
//   DCS       out  [NCH] confirmed channel states
//   DCSN      out  [NCH] registered complement of DCS
//   SD_OUT    out  serial readout data
//   SD_VALID  out  high while SD_OUT carries a bit
//   RD_BUSY   out  readout in progress
// ----------------------------------------------------------------------------
module sd_sampler_n #(
   parameter int NCH  = 4,
   parameter int FILT = 3
) (
   input  logic           SIM_CLK,
   input  logic           SIM_RST,
   input  logic           SAMP,
   input  logic [NCH-1:0] DIN,
   input  logic [NCH-1:0] GATE,
   input  logic [NCH-1:0] STICKY,
   input  logic           CLR,
   input  logic           RD_REQ,
   output logic [NCH-1:0] DCS,
   output logic [NCH-1:0] DCSN,
   output logic           SD_OUT,
   output logic           SD_VALID,
   output logic           RD_BUSY
);

   localparam int              KW     = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [2:0]      FILT_C = 3'(FILT);
   localparam logic [KW-1:0]   K_LAST = KW'(NCH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rd_state_e;

   logic [NCH-1:0]      cand_q, cand_d;
   logic [NCH-1:0][2:0] cnt_q,  cnt_d;
   logic [NCH-1:0]      dcs_q,  dcs_d;
   logic [NCH-1:0]      dcsn_q, dcsn_d;
   logic [NCH-1:0]      snap_q, snap_d;
   logic [KW-1:0]       k_q,    k_d;
   logic [KW-1:0]       k_inc_s;
   rd_state_e           state_q, state_d;
   logic                sd_out_q,   sd_out_d;
   logic                sd_valid_q, sd_valid_d;
   logic                rd_busy_q,  rd_busy_d;

   assign k_inc_s = k_q + KW'(1'b1);

   // Per-channel filter: candidate/count update and confirmation into DCS.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      dcs_d  = dcs_q;
      for (int i = 0; i < NCH; i++) begin
         if (CLR) begin
            cand_d[i] = 1'b0;
            cnt_d[i]  = 3'd0;
            dcs_d[i]  = 1'b0;
         end else if (SAMP && GATE[i]) begin
            if (DIN[i] == cand_q[i]) begin
               if (cnt_q[i] >= FILT_C) begin
                  cnt_d[i] = FILT_C;
               end else begin
                  cnt_d[i] = cnt_q[i] + 3'd1;
               end
            end else begin
               cand_d[i] = DIN[i];
               cnt_d[i]  = 3'd1;
            end
            // Confirmation is judged on the updated count, so it lands on the
            // same edge that registers the confirming sample.
            if (cnt_d[i] == FILT_C) begin
               if (STICKY[i]) begin
                  if (cand_d[i]) begin
                     dcs_d[i] = 1'b1;
                  end else begin
                     dcs_d[i] = dcs_q[i];
                  end
               end else begin
                  dcs_d[i] = cand_d[i];
               end
            end else begin
               dcs_d[i] = dcs_q[i];
            end
         end else begin
            cand_d[i] = cand_q[i];
            cnt_d[i]  = cnt_q[i];
            dcs_d[i]  = dcs_q[i];
         end
      end
      dcsn_d = ~dcs_d;
   end

   // Readout FSM: next state and next registered serial outputs.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      snap_d     = snap_q;
      sd_out_d   = 1'b0;
      sd_valid_d = 1'b0;
      rd_busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (RD_REQ) begin
               // Snapshot the word as registered before this edge's updates.
               state_d    = ST_SHIFT;
               k_d        = '0;
               snap_d     = dcs_q;
               sd_out_d   = dcs_q[0];
               sd_valid_d = 1'b1;
               rd_busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (k_q == K_LAST) begin
               state_d = ST_IDLE;
            end else begin
               k_d        = k_inc_s;
               sd_out_d   = snap_q[k_inc_s];
               sd_valid_d = 1'b1;
               rd_busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         cand_q     <= '0;
         cnt_q      <= '0;
         dcs_q      <= '0;
         dcsn_q     <= '1;
         snap_q     <= '0;
         k_q        <= '0;
         state_q    <= ST_IDLE;
         sd_out_q   <= 1'b0;
         sd_valid_q <= 1'b0;
         rd_busy_q  <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         dcs_q      <= dcs_d;
         dcsn_q     <= dcsn_d;
         snap_q     <= snap_d;
         k_q        <= k_d;
         state_q    <= state_d;
         sd_out_q   <= sd_out_d;
         sd_valid_q <= sd_valid_d;
         rd_busy_q  <= rd_busy_d;
      end
   end

   assign DCS      = dcs_q;
   assign DCSN     = dcsn_q;
   assign SD_OUT   = sd_out_q;
   assign SD_VALID = sd_valid_q;
   assign RD_BUSY  = rd_busy_q;

endmodule

// File: tb/tb_sd_sampler_n.sv
// ----------------------------------------------------------------------------
// tb_sd_sampler_n
//   Directed bench for sd_sampler_n. u_dut uses FILT=3, u_dut1 uses FILT=1;
//   both share the same stimulus. Expected values are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_sd_sampler_n;

   logic       clk;
   logic       rst;
   logic       samp;
   logic [3:0] din;
   logic [3:0] gate;
   logic [3:0] sticky;
   logic       clr;
   logic       rd_req;

   logic [3:0] dcs,  dcsn;
   logic       sd_out, sd_valid, rd_busy;
   logic [3:0] dcs1, dcsn1;
   logic       sd_out1, sd_valid1, rd_busy1;

   int n_cmp = 0;
   int n_bad = 0;

   sd_sampler_n #(.NCH(4), .FILT(3)) u_dut (
      .SIM_CLK(clk), .SIM_RST(rst), .SAMP(samp), .DIN(din), .GATE(gate),
      .STICKY(sticky), .CLR(clr), .RD_REQ(rd_req),
      .DCS(dcs), .DCSN(dcsn), .SD_OUT(sd_out), .SD_VALID(sd_valid),
      .RD_BUSY(rd_busy)
   );

   sd_sampler_n #(.NCH(4), .FILT(1)) u_dut1 (
      .SIM_CLK(clk), .SIM_RST(rst), .SAMP(samp), .DIN(din), .GATE(gate),
      .STICKY(sticky), .CLR(clr), .RD_REQ(rd_req),
      .DCS(dcs1), .DCSN(dcsn1), .SD_OUT(sd_out1), .SD_VALID(sd_valid1),
      .RD_BUSY(rd_busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One sample strobe; returns at the negedge after the capturing posedge.
   task automatic pulse(input logic [3:0] d);
      @(negedge clk);
      din  = d;
      samp = 1'b1;
      @(negedge clk);
      samp = 1'b0;
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; samp = 1'b0; din = 4'h0; gate = 4'h0; sticky = 4'h0;
      clr = 1'b0; rd_req = 1'b0;
      #12;
      n_cmp++; if (dcs !== 4'h0)     begin n_bad++; $display("FAIL reset_dcs got %h want 0", dcs); end
      n_cmp++; if (dcsn !== 4'hF)    begin n_bad++; $display("FAIL reset_dcsn got %h want f", dcsn); end
      n_cmp++; if (rd_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", rd_busy); end
      n_cmp++; if (sd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sd_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (dcs !== 4'h0 || dcsn !== 4'hF) begin n_bad++; $display("FAIL idle_dcs got %h/%h want 0/f", dcs, dcsn); end
   endtask

   task automatic test_filter();
      gate = 4'b0001; sticky = 4'b0000;
      pulse(4'b0001);
      n_cmp++; if (dcs[0] !== 1'b0) begin n_bad++; $display("FAIL filt_p1 got %b want 0", dcs[0]); end
      pulse(4'b0001);
      n_cmp++; if (dcs[0] !== 1'b0) begin n_bad++; $display("FAIL filt_p2 got %b want 0", dcs[0]); end
      pulse(4'b0001);
      n_cmp++; if (dcs !== 4'b0001 || dcsn !== 4'b1110) begin n_bad++; $display("FAIL filt_p3 got %b/%b want 0001/1110", dcs, dcsn); end
      do_clr();
      n_cmp++; if (dcs !== 4'b0000) begin n_bad++; $display("FAIL filt_clr got %b want 0000", dcs); end
      // 1,1,0,1,1 : never three consecutive ones
      pulse(4'b0001); pulse(4'b0001); pulse(4'b0000); pulse(4'b0001); pulse(4'b0001);
      n_cmp++; if (dcs[0] !== 1'b0) begin n_bad++; $display("FAIL filt_broken got %b want 0", dcs[0]); end
      pulse(4'b0001);
      n_cmp++; if (dcs[0] !== 1'b1) begin n_bad++; $display("FAIL filt_third got %b want 1", dcs[0]); end
      // level mode follows a confirmed 0
      pulse(4'b0000); pulse(4'b0000);
      n_cmp++; if (dcs[0] !== 1'b1) begin n_bad++; $display("FAIL filt_lvl2 got %b want 1", dcs[0]); end
      pulse(4'b0000);
      n_cmp++; if (dcs[0] !== 1'b0) begin n_bad++; $display("FAIL filt_lvl3 got %b want 0", dcs[0]); end
   endtask

   task automatic test_gate();
      do_clr();
      gate = 4'b0010; sticky = 4'b0000;
      pulse(4'b0010); pulse(4'b0010);
      gate = 4'b0000;
      for (int i = 0; i < 10; i++) pulse((i % 2 == 0) ? 4'b0000 : 4'b0010);
      n_cmp++; if (dcs !== 4'b0000) begin n_bad++; $display("FAIL gate_hold got %b want 0000", dcs); end
      gate = 4'b0010;
      pulse(4'b0010);
      n_cmp++; if (dcs !== 4'b0010) begin n_bad++; $display("FAIL gate_resume got %b want 0010", dcs); end
   endtask

   task automatic test_sticky();
      do_clr();
      gate = 4'b0100; sticky = 4'b0100;
      pulse(4'b0100);
      n_cmp++; if (dcs1 !== 4'b0100) begin n_bad++; $display("FAIL sticky_set got %b want 0100", dcs1); end
      pulse(4'b0000);
      pulse(4'b0000);
      n_cmp++; if (dcs1 !== 4'b0100 || dcsn1 !== 4'b1011) begin n_bad++; $display("FAIL sticky_hold got %b/%b want 0100/1011", dcs1, dcsn1); end
      pulse(4'b0100); pulse(4'b0100);
      n_cmp++; if (dcs !== 4'b0000) begin n_bad++; $display("FAIL sticky_f3 got %b want 0000", dcs); end
      // CLR together with a strobe that would otherwise confirm a 1
      @(negedge clk);
      din = 4'b0100; samp = 1'b1; clr = 1'b1;
      @(negedge clk);
      samp = 1'b0; clr = 1'b0;
      n_cmp++; if (dcs1 !== 4'b0000 || dcsn1 !== 4'b1111) begin n_bad++; $display("FAIL clr_prio1 got %b/%b want 0000/1111", dcs1, dcsn1); end
      n_cmp++; if (dcs !== 4'b0000) begin n_bad++; $display("FAIL clr_prio3 got %b want 0000", dcs); end
      pulse(4'b0100);
      n_cmp++; if (dcs !== 4'b0000) begin n_bad++; $display("FAIL clr_cnt got %b want 0000", dcs); end
      n_cmp++; if (dcs1 !== 4'b0100) begin n_bad++; $display("FAIL clr_resample got %b want 0100", dcs1); end
   endtask

   task automatic test_readout();
      logic [3:0] exp_w;
      exp_w = 4'b1010;
      do_clr();
      gate = 4'b1010; sticky = 4'b0000;
      pulse(4'b1010); pulse(4'b1010); pulse(4'b1010);
      n_cmp++; if (dcs !== 4'b1010) begin n_bad++; $display("FAIL rd_setup got %b want 1010", dcs); end
      @(negedge clk);
      rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rd_req = (k == 0 || k == 3) ? 1'b1 : 1'b0;
         n_cmp++;
         if (sd_valid !== 1'b1 || rd_busy !== 1'b1 || sd_out !== exp_w[k]) begin
            n_bad++;
            $display("FAIL rd_bit%0d got v=%b b=%b d=%b want v=1 b=1 d=%b", k, sd_valid, rd_busy, sd_out, exp_w[k]);
         end
      end
      @(negedge clk);
      rd_req = 1'b0;
      n_cmp++; if (sd_valid !== 1'b0 || rd_busy !== 1'b0 || sd_out !== 1'b0) begin n_bad++; $display("FAIL rd_end got v=%b b=%b d=%b want 0 0 0", sd_valid, rd_busy, sd_out); end
      @(negedge clk);
      n_cmp++; if (sd_valid !== 1'b0 || rd_busy !== 1'b0) begin n_bad++; $display("FAIL rd_ignored got v=%b b=%b want 0 0", sd_valid, rd_busy); end
   endtask

   task automatic test_same_cycle();
      do_clr();
      gate = 4'b1000; sticky = 4'b0000;
      pulse(4'b1000); pulse(4'b1000);
      @(negedge clk);
      din = 4'b1000; samp = 1'b1; rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         samp = 1'b0; rd_req = 1'b0;
         n_cmp++;
         if (sd_valid !== 1'b1 || sd_out !== 1'b0) begin
            n_bad++;
            $display("FAIL same_bit%0d got v=%b d=%b want v=1 d=0", k, sd_valid, sd_out);
         end
      end
      n_cmp++; if (dcs !== 4'b1000) begin n_bad++; $display("FAIL same_dcs got %b want 1000", dcs); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      n_cmp++; if (sd_out !== 1'b1 || rd_busy !== 1'b1) begin n_bad++; $display("FAIL arst_pre got d=%b b=%b want 1 1", sd_out, rd_busy); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (dcs !== 4'h0 || dcsn !== 4'hF || sd_out !== 1'b0 || sd_valid !== 1'b0 || rd_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL arst got dcs=%b dcsn=%b d=%b v=%b b=%b want 0000 1111 0 0 0", dcs, dcsn, sd_out, sd_valid, rd_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (rd_busy !== 1'b0 || dcs !== 4'h0) begin n_bad++; $display("FAIL arst_after got b=%b dcs=%b want 0 0000", rd_busy, dcs); end
   endtask

   initial begin
      test_reset();
      test_filter();
      test_gate();
      test_sticky();
      test_readout();
      test_same_cycle();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
